periph_access_sched: RTL and testbench

- Sequences uncached peripheral accesses from two requesters onto one shared peripheral port. Requester 0 is the LSU and requester 1 is the IFU.
- Each transaction goes through arbitration, then a programmable region decode, then the peripheral handshake, then a one-cycle response.
- Regions are configured by base/range/supported/size-mask/write-enable vectors. An illegal access, or a peripheral that never answers, returns a fault without hanging the core.
- Sits between the MMU/PMA checks and the peripheral bus interface.

---
 rtl/periph_access_sched_if.sv | 53 +++++
 rtl/periph_access_sched.sv | 173 +++++++++++++++++
 tb/tb_periph_access_sched.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/periph_access_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : periph_access_sched_if
//  Description : Bundle of requester, region-configuration and peripheral-port
//                signals for the uncached peripheral access scheduler.
//                "slave" is the scheduler's view, "master" the environment's.
//  Revision    : 1.0  initial release
// ============================================================================
interface periph_access_sched_if #(
    parameter int PA_BITS = 34,
    parameter int NREG    = 4
);
    // requester side (index 0 = LSU, index 1 = IFU)
    logic [1:0]              Req;
    logic [2*PA_BITS-1:0]    Adr;
    logic [1:0]              Write;
    logic [3:0]              Size;
    logic [1:0]              Done;
    logic                    Fault;
    logic                    Busy;

    // region configuration (quasi-static)
    logic [NREG*PA_BITS-1:0] RegionBase;
    logic [NREG*PA_BITS-1:0] RegionRange;
    logic [NREG-1:0]         RegionSupported;
    logic [4*NREG-1:0]       RegionSizeMask;
    logic [NREG-1:0]         RegionWrOK;

    // shared peripheral port
    logic [NREG-1:0]         PSel;
    logic                    PValid;
    logic [PA_BITS-1:0]      PAdr;
    logic                    PWrite;
    logic [1:0]              PSize;
    logic                    PReady;

    modport slave (
        input  Req, Adr, Write, Size,
        input  RegionBase, RegionRange, RegionSupported, RegionSizeMask, RegionWrOK,
        input  PReady,
        output PSel, PValid, PAdr, PWrite, PSize,
        output Done, Fault, Busy
    );

    modport master (
        output Req, Adr, Write, Size,
        output RegionBase, RegionRange, RegionSupported, RegionSizeMask, RegionWrOK,
        output PReady,
        input  PSel, PValid, PAdr, PWrite, PSize,
        input  Done, Fault, Busy
    );
endinterface
`default_nettype wire

// File: rtl/periph_access_sched.sv
`default_nettype none
// ============================================================================
//  Module      : periph_access_sched
//  Description : Round-robin scheduler of uncached accesses from the LSU (0)
//                and IFU (1) onto one shared peripheral port. Each access is
//                arbitrated, decoded against NREG programmable regions, run
//                through the PValid/PReady handshake with a timeout, and
//                answered with a one-cycle Done pulse qualified by Fault.
//  Revision    : 1.0  initial release
// ============================================================================
module periph_access_sched #(
    parameter int PA_BITS = 34,
    parameter int NREG    = 4,
    parameter int TIMEOUT = 15
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    periph_access_sched_if.slave  bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    // counter only has to reach TIMEOUT-1
    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]          r_state;
    logic                r_grant;
    logic                r_last_grant;
    logic [CNT_W-1:0]    r_cnt;
    logic [NREG-1:0]     r_psel;
    logic                r_pvalid;
    logic [PA_BITS-1:0]  r_padr;
    logic                r_pwrite;
    logic [1:0]          r_psize;
    logic [1:0]          r_done;
    logic                r_fault;
    logic                r_busy;

    logic                w_grant;
    logic [1:0]          w_done_vec;
    logic [NREG-1:0]     w_match;
    logic [NREG-1:0]     w_legal;
    logic [NREG-1:0]     w_win;
    logic                w_win_legal;

    // Per-region address match and legality against the latched access
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_region
            logic [PA_BITS-1:0] w_base;
            logic [PA_BITS-1:0] w_range;
            logic [3:0]         w_szmask;

            assign w_base      = bus.RegionBase[gi*PA_BITS +: PA_BITS];
            assign w_range     = bus.RegionRange[gi*PA_BITS +: PA_BITS];
            assign w_szmask    = bus.RegionSizeMask[gi*4 +: 4];
            // every bit either equals the base or is masked out by the range
            assign w_match[gi] = &((~(r_padr ^ w_base)) | w_range);
            assign w_legal[gi] = w_match[gi]
                               & bus.RegionSupported[gi]
                               & w_szmask[r_psize]
                               & (~r_pwrite | bus.RegionWrOK[gi]);
        end
    endgenerate

    // lowest-index matching region wins, even if that region is illegal
    assign w_win       = w_match & (~w_match + NREG'(1));
    assign w_win_legal = |(w_win & w_legal);

    assign w_done_vec  = r_grant ? 2'b10 : 2'b01;

    // Arbitration: a lone requester wins; on a tie the one not granted last
    always_comb begin
        w_grant = 1'b0;
        if (bus.Req == 2'b11) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = bus.Req[1];
        end
    end

    // Transaction sequencer: IDLE -> DECODE -> (ACCESS) -> RESP -> IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_psel       <= '0;
            r_pvalid     <= 1'b0;
            r_padr       <= '0;
            r_pwrite     <= 1'b0;
            r_psize      <= 2'b00;
            r_done       <= 2'b00;
            r_fault      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            // Done/Fault are single-cycle pulses in RESP only
            r_done  <= 2'b00;
            r_fault <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|bus.Req) begin
                        r_grant      <= w_grant;
                        r_last_grant <= w_grant;
                        r_padr       <= w_grant ? bus.Adr[2*PA_BITS-1:PA_BITS]
                                                : bus.Adr[PA_BITS-1:0];
                        r_pwrite     <= w_grant ? bus.Write[1] : bus.Write[0];
                        r_psize      <= w_grant ? bus.Size[3:2] : bus.Size[1:0];
                        r_busy       <= 1'b1;
                        r_state      <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_win_legal) begin
                        r_psel   <= w_win;
                        r_pvalid <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_ACCESS;
                    end else begin
                        // no match or illegal winner: fault without touching the bus
                        r_done   <= w_done_vec;
                        r_fault  <= 1'b1;
                        r_state  <= S_RESP;
                    end
                end
                S_ACCESS: begin
                    if (bus.PReady) begin
                        // a ready on the last counted cycle still completes cleanly
                        r_psel   <= '0;
                        r_pvalid <= 1'b0;
                        r_done   <= w_done_vec;
                        r_fault  <= 1'b0;
                        r_state  <= S_RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        r_psel   <= '0;
                        r_pvalid <= 1'b0;
                        r_done   <= w_done_vec;
                        r_fault  <= 1'b1;
                        r_state  <= S_RESP;
                    end else begin
                        r_cnt    <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_psel   <= '0;
                    r_pvalid <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.PSel   = r_psel;
    assign bus.PValid = r_pvalid;
    assign bus.PAdr   = r_padr;
    assign bus.PWrite = r_pwrite;
    assign bus.PSize  = r_psize;
    assign bus.Done   = r_done;
    assign bus.Fault  = r_fault;
    assign bus.Busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_periph_access_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_periph_access_sched
//  Description : Scoreboard bench for periph_access_sched. Expected responses
//                are queued when a request is driven and compared when Done
//                pulses; a small peripheral model drives PReady.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_periph_access_sched;

    localparam int PA_BITS = 34;
    localparam int NREG    = 4;
    localparam int TIMEOUT = 15;

    typedef struct {
        logic [1:0]         done;
        logic               fault;
        int                 pv;
        logic [NREG-1:0]    psel;
        logic [PA_BITS-1:0] adr;
        logic               wr;
        logic [1:0]         sz;
        int                 lat;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    exp_t            sb[$];
    int              n_checks  = 0;
    int              n_errors  = 0;
    int              cyc       = 0;
    int              pv_cnt    = 0;
    logic [NREG-1:0] psel_seen = '0;
    int              ready_at  = 0;
    logic            stray     = 1'b0;
    int              t_req[2];

    periph_access_sched_if #(.PA_BITS(PA_BITS), .NREG(NREG)) bus ();

    periph_access_sched #(
        .PA_BITS (PA_BITS),
        .NREG    (NREG),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // clock
    always #5 clk = ~clk;

    // cycle counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    // peripheral model: counts PValid cycles and answers on cycle ready_at
    always @(negedge clk) begin
        if (!reset_n) begin
            pv_cnt     = 0;
            psel_seen  = '0;
            bus.PReady = 1'b0;
        end else begin
            if (bus.PValid) begin
                pv_cnt++;
                psel_seen  = bus.PSel;
                bus.PReady = (ready_at > 0) && (pv_cnt == ready_at);
            end else begin
                bus.PReady = stray;
            end
            if (bus.Done != 2'b00) begin
                pv_cnt    = 0;
                psel_seen = '0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // wait for a Done pulse, pop the scoreboard and compare the response
    task automatic wait_done(input int r);
        logic got;
        exp_t e;
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(posedge clk);
            #2;
            if (bus.Done != 2'b00) begin
                got = 1'b1;
                if (sb.size() == 0) begin
                    check("spurious_done", 64'(bus.Done), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("done",     64'(bus.Done),   64'(e.done));
                    check("fault",    64'(bus.Fault),  64'(e.fault));
                    check("pv_cycles",64'(pv_cnt),     64'(e.pv));
                    check("psel",     64'(psel_seen),  64'(e.psel));
                    check("padr",     64'(bus.PAdr),   64'(e.adr));
                    check("pwrite",   64'(bus.PWrite), 64'(e.wr));
                    check("psize",    64'(bus.PSize),  64'(e.sz));
                    check("latency",  64'(cyc - t_req[r]), 64'(e.lat));
                    check("busy_resp",64'(bus.Busy),   64'd1);
                    check("pvalid_resp", 64'(bus.PValid), 64'd0);
                end
            end
        end
        if (!got) check("done_timeout", 64'd0, 64'd1);
    endtask

    function automatic exp_t mk(input int r, input logic [PA_BITS-1:0] adr, input logic wr,
                                input logic [1:0] sz, input logic efault,
                                input logic [NREG-1:0] epsel, input int epv, input int lat);
        exp_t e;
        e.done  = (r == 1) ? 2'b10 : 2'b01;
        e.fault = efault;
        e.pv    = epv;
        e.psel  = epsel;
        e.adr   = adr;
        e.wr    = wr;
        e.sz    = sz;
        e.lat   = lat;
        return e;
    endfunction

    // one complete transaction from a single requester
    task automatic do_txn(input int r, input logic [PA_BITS-1:0] adr, input logic wr,
                          input logic [1:0] sz, input int rdy, input logic efault,
                          input logic [NREG-1:0] epsel, input int epv);
        @(posedge clk);
        #1;
        bus.Adr[r*PA_BITS +: PA_BITS] = adr;
        bus.Write[r]                  = wr;
        bus.Size[r*2 +: 2]            = sz;
        ready_at                      = rdy;
        sb.push_back(mk(r, adr, wr, sz, efault, epsel, epv, 2 + epv));
        bus.Req[r] = 1'b1;
        t_req[r]   = cyc;
        wait_done(r);
        @(posedge clk);
        #1;
        bus.Req[r] = 1'b0;
    endtask

    // both requesters contend; requester 0 re-requests right after its Done
    task automatic dual_rr();
        @(posedge clk);
        #1;
        bus.Adr    = {34'h004002020, 34'h004002010};
        bus.Write  = 2'b00;
        bus.Size   = 4'b1010;
        ready_at   = 1;
        sb.push_back(mk(0, 34'h004002010, 1'b0, 2'd2, 1'b0, 4'b0001, 1, 3));
        sb.push_back(mk(1, 34'h004002020, 1'b0, 2'd2, 1'b0, 4'b0001, 1, 7));
        sb.push_back(mk(0, 34'h004002010, 1'b0, 2'd2, 1'b0, 4'b0001, 1, 7));
        bus.Req  = 2'b11;
        t_req[0] = cyc;
        t_req[1] = cyc;
        wait_done(0);
        @(posedge clk);
        #1;
        t_req[0] = cyc;
        wait_done(1);
        @(posedge clk);
        #1;
        bus.Req[1] = 1'b0;
        wait_done(0);
        @(posedge clk);
        #1;
        bus.Req[0] = 1'b0;
    endtask

    initial begin
        bus.Req   = 2'b00;
        bus.Adr   = '0;
        bus.Write = 2'b00;
        bus.Size  = 4'b0000;
        bus.RegionBase      = {34'h020000000, 34'h030000000, 34'h020000000, 34'h004002000};
        bus.RegionRange     = {34'h0000FFFFF, 34'h0000000FF, 34'h00000FFFF, 34'h000000FFF};
        bus.RegionSupported = 4'b1011;
        bus.RegionSizeMask  = 16'hFFF4;
        bus.RegionWrOK      = 4'b1101;

        repeat (3) @(posedge clk);
        #2;
        check("rst_psel",   64'(bus.PSel),   64'd0);
        check("rst_pvalid", 64'(bus.PValid), 64'd0);
        check("rst_padr",   64'(bus.PAdr),   64'd0);
        check("rst_pwrite", 64'(bus.PWrite), 64'd0);
        check("rst_psize",  64'(bus.PSize),  64'd0);
        check("rst_done",   64'(bus.Done),   64'd0);
        check("rst_fault",  64'(bus.Fault),  64'd0);
        check("rst_busy",   64'(bus.Busy),   64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // round robin straight out of reset: 0, then 1, then 0
        dual_rr();
        // legal read in region 0, ready on second access cycle
        do_txn(0, 34'h004002010, 1'b0, 2'd2, 2, 1'b0, 4'b0001, 2);
        // no region matches
        do_txn(1, 34'h010000000, 1'b0, 2'd2, 1, 1'b1, 4'b0000, 0);
        // region 1 wins over region 3 and forbids writes
        do_txn(0, 34'h020000100, 1'b1, 2'd2, 1, 1'b1, 4'b0000, 0);
        // overlapping regions 1 and 3: region 1 selected
        do_txn(1, 34'h020000100, 1'b0, 2'd3, 1, 1'b0, 4'b0010, 1);
        // 64-bit access to a 32-bit-only region
        do_txn(0, 34'h004002010, 1'b0, 2'd3, 1, 1'b1, 4'b0000, 0);
        // only region 3 matches, write allowed
        do_txn(1, 34'h020010000, 1'b1, 2'd0, 3, 1'b0, 4'b1000, 3);
        // region 2 matches but is not present
        do_txn(0, 34'h030000010, 1'b0, 2'd2, 1, 1'b1, 4'b0000, 0);
        // peripheral never answers: full timeout
        do_txn(0, 34'h004002FF8, 1'b0, 2'd2, 0, 1'b1, 4'b0001, TIMEOUT);
        // ready on the very last counted cycle wins
        do_txn(1, 34'h004002000, 1'b0, 2'd2, TIMEOUT, 1'b0, 4'b0001, TIMEOUT);
        // PReady floating high outside ACCESS is ignored
        stray = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("stray_ready_idle_busy", 64'(bus.Busy), 64'd0);
        do_txn(0, 34'h004002010, 1'b0, 2'd2, 1, 1'b0, 4'b0001, 1);
        stray = 1'b0;

        // reset in the middle of an access aborts it silently
        @(posedge clk);
        #1;
        bus.Adr[PA_BITS-1:0] = 34'h004002010;
        bus.Write[0]         = 1'b0;
        bus.Size[1:0]        = 2'd2;
        ready_at             = 0;
        bus.Req[0]           = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        check("abort_pvalid_before", 64'(bus.PValid), 64'd1);
        reset_n = 1'b0;
        #1;
        check("abort_pvalid", 64'(bus.PValid), 64'd0);
        check("abort_psel",   64'(bus.PSel),   64'd0);
        check("abort_busy",   64'(bus.Busy),   64'd0);
        check("abort_done",   64'(bus.Done),   64'd0);
        bus.Req[0] = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #2;
            check("no_done_after_abort", 64'(bus.Done), 64'd0);
        end
        // last grant before reset was 0; reset must give requester 0 priority again
        dual_rr();

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // guard against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion before limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
